// File: rtl/mlp_tm_stream.sv
// Time-multiplexed two-layer MLP core with valid/ready streaming.
// One N1-wide multiply/adder-tree lane is reused across all N2 hidden neurons,
// with one neuron issued per cycle. Weights are loaded through a write port.
module mlp_tm_stream #(
    parameter int N1   = 98,
    parameter int N2   = 20,
    parameter int W_X  = 4,
    parameter int W_K  = 4,
    parameter int RELU = 1,
    parameter int D1   = $clog2(N1),
    parameter int W_A  = W_X + W_K + $clog2(N1),
    parameter int W_Y  = W_A + W_K + $clog2(N2),
    parameter int W_WA = $clog2(N2 * N1 + N2)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N1*W_X-1:0]     in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [W_Y-1:0] out_y,
    input  logic                  w_we,
    input  logic [W_WA-1:0]       w_addr,
    input  logic [W_K-1:0]        w_data
);

    localparam int IW = (N2 > 1) ? $clog2(N2) : 1;
    localparam int L  = 1 << D1;
    localparam int NP = D1 + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [W_K-1:0]        w1_mem [N2][N1];
    logic [W_K-1:0]        w2_mem [N2];
    logic [N1*W_X-1:0]     x_reg;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_pipe [D1+1];
    logic [NP-1:0]         v_pipe;
    logic [NP-1:0]         last_pipe;
    logic signed [W_A-1:0] prod_next [L];
    logic signed [W_A-1:0] node [1:2*L-1];
    logic signed [W_A-1:0] root;
    logic signed [W_A-1:0] act;
    logic signed [W_Y-1:0] act_e;
    logic signed [W_Y-1:0] h_next;
    logic signed [W_Y-1:0] h_reg;
    logic signed [W_Y-1:0] acc;
    logic [W_K-1:0]        w2v;
    logic                  accept;
    logic                  issue;
    logic                  last_issue;
    logic                  fin;
    logic                  wr_en;

    assign accept     = in_valid && in_ready;
    assign last_issue = issue && (idx == IW'(N2 - 1));
    assign fin        = v_pipe[NP-1] && last_pipe[NP-1];
    assign wr_en      = w_we && rstn && (state == IDLE);

    // State register, returns to IDLE on reset
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: accept, issue N2 neurons, drain the pipeline, hold result
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (idx == IW'(N2 - 1)) state_next = DRAIN;
            DRAIN:   if (fin) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; in_ready is forced low while reset is asserted
    always_comb begin
        in_ready  = rstn && (state == IDLE);
        issue     = (state == RUN);
        out_valid = (state == DONE);
    end

    // Weight RAM, written only while idle; out-of-range addresses match nothing
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int a = 0; a < N2; a++)
                for (int b = 0; b < N1; b++)
                    if (w_addr == W_WA'(a * N1 + b)) w1_mem[a][b] <= w_data;
            for (int a = 0; a < N2; a++)
                if (w_addr == W_WA'(N2 * N1 + a)) w2_mem[a] <= w_data;
        end
    end

    // First-layer products for the neuron being issued, padded with zeros to a power of two
    for (genvar n = 0; n < L; n++) begin : g_prod
        if (n < N1) begin : g_lane
            logic signed [W_X-1:0] xv;
            logic [W_K-1:0]        wv;
            logic signed [W_A-1:0] xe;
            assign xv = x_reg[n*W_X +: W_X];
            assign wv = w1_mem[idx][n];
            assign xe = {{(W_A-W_X){xv[W_X-1]}}, xv};
            if (W_K == 1) begin : g_sign
                assign prod_next[n] = wv[0] ? -xe : xe;
            end else begin : g_mult
                logic signed [W_A-1:0] we;
                assign we = {{(W_A-W_K){wv[W_K-1]}}, wv};
                assign prod_next[n] = xe * we;
            end
        end else begin : g_pad
            assign prod_next[n] = '0;
        end
    end

    // Activation on the tree root, then scale by the second-layer weight
    assign root  = node[1];
    assign act   = (RELU != 0 && root[W_A-1]) ? '0 : root;
    assign w2v   = w2_mem[idx_pipe[D1]];
    assign act_e = {{(W_Y-W_A){act[W_A-1]}}, act};

    if (W_K == 1) begin : g_h_sign
        assign h_next = w2v[0] ? -act_e : act_e;
    end else begin : g_h_mult
        logic signed [W_Y-1:0] w2e;
        assign w2e    = {{(W_Y-W_K){w2v[W_K-1]}}, w2v};
        assign h_next = act_e * w2e;
    end

    // Datapath registers: input latch, product leaves, tree levels, H stage, index tags
    always_ff @(posedge clk) begin
        if (accept) x_reg <= in_x;
        for (int n = 0; n < L; n++) node[L+n] <= prod_next[n];
        for (int k = 1; k < L; k++) node[k] <= node[2*k] + node[2*k+1];
        h_reg       <= h_next;
        idx_pipe[0] <= idx;
        for (int s = 1; s <= D1; s++) idx_pipe[s] <= idx_pipe[s-1];
    end

    // Control: issue index, pipeline valid/last tags, accumulator and result
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx       <= '0;
            v_pipe    <= '0;
            last_pipe <= '0;
            acc       <= '0;
            out_y     <= '0;
        end else begin
            if (accept)     idx <= '0;
            else if (issue) idx <= idx + IW'(1);
            v_pipe    <= {v_pipe[NP-2:0], issue};
            last_pipe <= {last_pipe[NP-2:0], last_issue};
            if (accept)            acc <= '0;
            else if (v_pipe[NP-1]) acc <= acc + h_reg;
            if (fin) out_y <= acc + h_reg;
        end
    end

endmodule

// File: tb/tb_mlp_tm_stream.sv
// Self-checking bench for mlp_tm_stream: a transaction-level model of the
// MLP arithmetic and handshake timing, plus directed literal checks, and two
// extra instances covering the RELU=0 and sign-mode builds.
module tb_mlp_tm_stream;

    localparam int N1   = 98;
    localparam int N2   = 20;
    localparam int W_X  = 4;
    localparam int D1   = 7;
    localparam int W_Y  = 24;
    localparam int W_YS = 18;
    localparam int W_WA = 11;
    localparam int LAT  = N2 + D1 + 2;
    localparam int NW1  = N2 * N1;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  in_valid;
    logic                  in_ready;
    logic [N1*W_X-1:0]     in_x;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [W_Y-1:0] out_y;
    logic                  w_we;
    logic [W_WA-1:0]       w_addr;
    logic [3:0]            w_data;

    logic                   in_valid_b;
    logic [N1*W_X-1:0]      in_x_b;
    logic                   w_we_b;
    logic [W_WA-1:0]        w_addr_b;
    logic [3:0]             w_data_r0;
    logic [0:0]             w_data_sg;
    logic                   out_ready_b;
    logic                   in_ready_r0, out_valid_r0;
    logic                   in_ready_sg, out_valid_sg;
    logic signed [W_Y-1:0]  out_y_r0;
    logic signed [W_YS-1:0] out_y_sg;

    int     n_cmp = 0;
    int     n_err = 0;
    bit     cmp_en = 1'b0;
    longint cyc = 0;
    longint acc_cyc = 0;

    int     mw1 [N2][N1];
    int     mw2 [N2];
    int     mx  [N1];
    int     m_phase = 0;
    int     m_cnt = 0;
    longint m_exp = 0;
    longint m_y = 0;

    mlp_tm_stream dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
    );

    mlp_tm_stream #(.RELU(0)) dut_r0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_r0), .in_x(in_x_b),
        .out_valid(out_valid_r0), .out_ready(out_ready_b), .out_y(out_y_r0),
        .w_we(w_we_b), .w_addr(w_addr_b), .w_data(w_data_r0)
    );

    mlp_tm_stream #(.W_K(1), .RELU(0)) dut_sg (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_sg), .in_x(in_x_b),
        .out_valid(out_valid_sg), .out_ready(out_ready_b), .out_y(out_y_sg),
        .w_we(w_we_b), .w_addr(w_addr_b), .w_data(w_data_sg)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // y = sum_n2 w2 * relu(sum_n1 w1 * x), straight from the definition
    function automatic longint model_y();
        longint y = 0;
        for (int a = 0; a < N2; a++) begin
            longint h = 0;
            for (int b = 0; b < N1; b++) h += longint'(mw1[a][b]) * longint'(mx[b]);
            if (h < 0) h = 0;
            y += h * longint'(mw2[a]);
        end
        return y;
    endfunction

    // Reference model: weights written while idle, sample captured at accept,
    // result presented a fixed number of edges later and held until taken
    always @(posedge clk) begin
        if (!rstn) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (w_we) begin
                        int a;
                        a = int'(w_addr);
                        if (a < NW1) mw1[a / N1][a % N1] = sx4(w_data);
                        else if (a < NW1 + N2) mw2[a - NW1] = sx4(w_data);
                    end
                    if (in_valid) begin
                        for (int b = 0; b < N1; b++) mx[b] = sx4(in_x[b*W_X +: W_X]);
                        m_exp   = model_y();
                        m_cnt   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == LAT) begin
                        m_phase = 2;
                        m_y     = m_exp;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Every-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("in_ready", longint'(in_ready), longint'(rstn && m_phase == 0));
            checkOutput("out_valid", longint'(out_valid), longint'(m_phase == 2));
            if (m_phase == 2) checkOutput("out_y", longint'(out_y), m_y);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_range(input int lo, input int hi, input logic [3:0] d);
        for (int a = lo; a <= hi; a++) begin
            w_we   = 1'b1;
            w_addr = W_WA'(a);
            w_data = d;
            tick();
        end
        w_we = 1'b0;
    endtask

    // Present one sample (optionally with a weight write on the same edge)
    task automatic applyStimulus(input logic [3:0] xv, input bit we, input int addr, input logic [3:0] d);
        in_x     = {N1{xv}};
        in_valid = 1'b1;
        w_we     = we;
        w_addr   = W_WA'(addr);
        w_data   = d;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        w_we     = 1'b0;
        in_x     = {N1{~xv}};
    endtask

    task automatic finish_sample(input string name, input longint exp, input bit chk_lat, input int hold);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checkOutput({name, "_timeout"}, 0, 1);
        end else begin
            if (chk_lat) checkOutput({name, "_latency"}, cyc - acc_cyc, LAT);
            checkOutput({name, "_y"}, longint'(out_y), exp);
            for (int h = 0; h < hold; h++) begin
                in_valid = (h % 2 == 0);
                tick();
            end
            in_valid = 1'b0;
            if (hold > 0) checkOutput({name, "_held_y"}, longint'(out_y), exp);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checkOutput({name, "_ready_after"}, longint'(in_ready), 1);
        end
    endtask

    // Hard stop if something wedges
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios
    initial begin
        bit seen;
        rstn = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid_b = 1'b0; in_x_b = '0; w_we_b = 1'b0; w_addr_b = '0;
        w_data_r0 = '0; w_data_sg = '0; out_ready_b = 1'b0;
        for (int a = 0; a < N2; a++) begin
            mw2[a] = 0;
            for (int b = 0; b < N1; b++) mw1[a][b] = 0;
        end

        repeat (3) tick();
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_y", longint'(out_y), 0);
        checkOutput("reset_in_ready", longint'(in_ready), 0);
        rstn = 1'b1;
        cmp_en = 1'b1;
        tick();

        // All ones: hidden 98 each, y = 1960; out-of-range writes ignored
        write_range(0, NW1 + N2 - 1, 4'h1);
        write_range(NW1 + N2, 2047, 4'h0);
        applyStimulus(4'h1, 1'b0, 0, 4'h0);
        finish_sample("base", 1960, 1'b1, 0);

        // w1 = -1: every hidden value negative, clamped to 0
        write_range(0, NW1 - 1, 4'hF);
        applyStimulus(4'h1, 1'b0, 0, 4'h0);
        finish_sample("relu_clamp", 0, 1'b0, 0);

        // Extremes, last w2 written on the accept edge itself
        write_range(0, NW1 - 1, 4'h8);
        write_range(NW1, NW1 + N2 - 2, 4'h8);
        write_range(NW1 + N2 - 1, NW1 + N2 - 1, 4'h1);
        applyStimulus(4'h8, 1'b1, NW1 + N2 - 1, 4'h8);
        finish_sample("extreme", -1003520, 1'b1, 0);

        // Backpressure for 10 cycles with ignored in_valid pulses
        applyStimulus(4'hF, 1'b0, 0, 4'h0);
        finish_sample("backpressure", -125440, 1'b1, 10);

        // Writes during RUN/DRAIN/DONE are dropped
        write_range(0, NW1 + N2 - 1, 4'h1);
        applyStimulus(4'h1, 1'b0, 0, 4'h0);
        write_range(0, NW1 - 1, 4'h0);
        finish_sample("busy_writes", 1960, 1'b0, 0);

        // The same writes while idle do take effect
        write_range(0, NW1 - 1, 4'h0);
        applyStimulus(4'h1, 1'b0, 0, 4'h0);
        finish_sample("idle_writes", 0, 1'b0, 0);

        // Reset ten edges into a computation aborts it
        write_range(0, NW1 - 1, 4'h1);
        applyStimulus(4'h1, 1'b0, 0, 4'h0);
        repeat (9) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", longint'(seen), 0);
        applyStimulus(4'h1, 1'b0, 0, 4'h0);
        finish_sample("after_abort", 1960, 1'b1, 0);

        // RELU=0 build (w1=-1, w2=1) and sign-mode build (all bits 1)
        for (int a = 0; a < NW1 + N2; a++) begin
            w_we_b    = 1'b1;
            w_addr_b  = W_WA'(a);
            w_data_r0 = (a < NW1) ? 4'hF : 4'h1;
            w_data_sg = 1'b1;
            tick();
        end
        w_we_b     = 1'b0;
        in_x_b     = {N1{4'h1}};
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        begin
            int n = 0;
            while (!out_valid_r0 && n < 100) begin
                tick();
                n++;
            end
            checkOutput("r0_latency", n, LAT);
        end
        checkOutput("r0_valid", longint'(out_valid_r0), 1);
        checkOutput("r0_y", longint'(out_y_r0), -1960);
        checkOutput("sign_valid", longint'(out_valid_sg), 1);
        checkOutput("sign_y", longint'(out_y_sg), 1960);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
